// File: rtl/control_unit_types_pkg.sv
// Purpose: control-path enums shared by pipeline stages.
package control_unit_types_pkg;

  // Write-back data source select
  typedef enum logic [1:0] {
    ALU = 2'd0,
    MEM = 2'd1,
    NPC = 2'd2
  } memtoreg_t;

  // Memory stage controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } memstate_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Purpose: shared CPU datapath types (word and register-index widths).
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

endpackage

// File: rtl/llsc_link.sv
// Purpose: load-linked / store-conditional link register.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   set, set_addr     LL completion: arm link on set_addr
//   clr               SC completion: disarm link
//   snoop_inv/addr    coherence invalidate; disarms on address match
//   valid, addr       current link state
import cpu_types_pkg::*;

module llsc_link (
  input  logic  CLK,
  input  logic  RST,
  input  logic  set,
  input  logic  clr,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  input  word_t set_addr,
  output logic  valid,
  output word_t addr
);

  logic  r_valid;
  word_t r_addr;

  // A same-cycle LL set takes priority over clear and snoop invalidate
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else if (set) begin
      r_valid <= 1'b1;
      r_addr  <= set_addr;
    end else if (clr || (snoop_inv && (snoop_addr == r_addr))) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign addr  = r_addr;

endmodule

// File: rtl/mem_stage.sv
// Purpose: pipeline MEM stage. Issues data-cache requests, stalls the
// front of the pipeline until the cache answers, resolves LL/SC, handles
// halt, and loads the MEM/WB register.
// Ports:
//   CLK, RST                         clock, synchronous active-high reset
//   mm_*                             EX/MEM register contents
//   dhit, dmemload                   cache response
//   dmemREN/WEN, dmemaddr/store      cache request (combinational)
//   snoop_inv, snoop_addr            coherence invalidate
//   mm_stall                         freeze IF..EX/MEM (combinational)
//   wb_*                             MEM/WB register
//   stall_cycles                     saturating count of stall cycles
import cpu_types_pkg::*;
import control_unit_types_pkg::*;

module mem_stage (
  input  logic      CLK,
  input  logic      RST,
  input  logic      mm_valid,
  input  logic      mm_dREN,
  input  logic      mm_dWEN,
  input  logic      mm_ll,
  input  logic      mm_sc,
  input  memtoreg_t mm_MemtoReg,
  input  logic      mm_RegWEN,
  input  logic      mm_halt,
  input  regbits_t  mm_rd,
  input  word_t     mm_ALUOut,
  input  word_t     mm_store,
  input  word_t     mm_npc,
  input  logic      dhit,
  input  word_t     dmemload,
  output logic      dmemREN,
  output logic      dmemWEN,
  output word_t     dmemaddr,
  output word_t     dmemstore,
  input  logic      snoop_inv,
  input  word_t     snoop_addr,
  output logic      mm_stall,
  output logic      wb_valid,
  output logic      wb_RegWEN,
  output logic      wb_halt,
  output regbits_t  wb_rd,
  output word_t     wb_wdat,
  output word_t     stall_cycles
);

  localparam word_t STALL_MAX = '1;

  memstate_t r_state;
  memstate_t w_state_nxt;
  logic      r_post_rst;

  logic  w_active;
  logic  w_halt;
  logic  w_sc_ok;
  logic  w_sc_fail;
  logic  w_req;
  logic  w_done;
  logic  w_link_valid;
  word_t w_link_addr;
  logic  w_link_set;
  logic  w_link_clr;
  word_t w_wdat;

  logic     r_wb_valid;
  logic     r_wb_RegWEN;
  logic     r_wb_halt;
  regbits_t r_wb_rd;
  word_t    r_wb_wdat;
  word_t    r_stall_cycles;

  // State register; r_post_rst blocks any access in the cycle after reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_post_rst <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_post_rst <= 1'b0;
    end
  end

  // Request/complete decode, next state and combinational cache outputs
  always_comb begin
    w_state_nxt = r_state;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    dmemaddr    = '0;
    dmemstore   = '0;
    mm_stall    = 1'b0;

    w_active  = (r_state != HALTED) && !r_post_rst && mm_valid;
    w_halt    = w_active && (r_state == IDLE) && mm_halt;
    w_sc_ok   = w_link_valid && (w_link_addr == mm_ALUOut);
    // A failed SC (including link lost while waiting) never touches the cache
    w_sc_fail = mm_sc && !w_sc_ok;
    w_req     = w_active && !w_halt && (mm_dREN || mm_dWEN) && !w_sc_fail;
    w_done    = w_active && (!w_req || dhit);

    if (w_req) begin
      dmemREN   = mm_dREN;
      dmemWEN   = mm_dWEN;
      dmemaddr  = mm_ALUOut;
      dmemstore = mm_store;
    end

    mm_stall = (r_state == HALTED) || (w_req && !dhit);

    case (r_state)
      IDLE: begin
        if (w_halt)
          w_state_nxt = HALTED;
        else if (w_req && !dhit)
          w_state_nxt = REQ;
      end
      REQ: begin
        if (!w_req || dhit)
          w_state_nxt = IDLE;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write-back data select
  always_comb begin
    w_wdat = mm_ALUOut;
    if (mm_sc) begin
      w_wdat = WORD_W'(w_req && dhit);
    end else begin
      case (mm_MemtoReg)
        ALU:     w_wdat = mm_ALUOut;
        MEM:     w_wdat = dmemload;
        NPC:     w_wdat = mm_npc;
        default: w_wdat = mm_ALUOut;
      endcase
    end
  end

  assign w_link_set = w_done && mm_ll && w_req;
  assign w_link_clr = w_done && mm_sc;

  llsc_link u_link (
    .CLK        (CLK),
    .RST        (RST),
    .set        (w_link_set),
    .clr        (w_link_clr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .set_addr   (mm_ALUOut),
    .valid      (w_link_valid),
    .addr       (w_link_addr)
  );

  // MEM/WB register; wb_halt stays high for as long as the stage is halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wb_valid  <= 1'b0;
      r_wb_RegWEN <= 1'b0;
      r_wb_halt   <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_wdat   <= '0;
    end else begin
      r_wb_valid  <= w_done;
      r_wb_RegWEN <= w_done && mm_RegWEN;
      r_wb_halt   <= w_halt || (r_state == HALTED);
      if (w_done) begin
        r_wb_rd   <= mm_rd;
        r_wb_wdat <= w_wdat;
      end
    end
  end

  // Saturating stall counter; halted stalls are not counted
  always_ff @(posedge CLK) begin
    if (RST)
      r_stall_cycles <= '0;
    else if (mm_stall && (r_state != HALTED) && (r_stall_cycles != STALL_MAX))
      r_stall_cycles <= r_stall_cycles + WORD_W'(1);
  end

  assign wb_valid     = r_wb_valid;
  assign wb_RegWEN    = r_wb_RegWEN;
  assign wb_halt      = r_wb_halt;
  assign wb_rd        = r_wb_rd;
  assign wb_wdat      = r_wb_wdat;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: directed self-checking bench for mem_stage.
import cpu_types_pkg::*;
import control_unit_types_pkg::*;

module tb_mem_stage;

  logic      CLK = 1'b0;
  logic      RST;
  logic      mm_valid, mm_dREN, mm_dWEN, mm_ll, mm_sc, mm_RegWEN, mm_halt;
  memtoreg_t mm_MemtoReg;
  regbits_t  mm_rd;
  word_t     mm_ALUOut, mm_store, mm_npc;
  logic      dhit;
  word_t     dmemload;
  logic      dmemREN, dmemWEN;
  word_t     dmemaddr, dmemstore;
  logic      snoop_inv;
  word_t     snoop_addr;
  logic      mm_stall;
  logic      wb_valid, wb_RegWEN, wb_halt;
  regbits_t  wb_rd;
  word_t     wb_wdat;
  word_t     stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .mm_valid(mm_valid), .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN),
    .mm_ll(mm_ll), .mm_sc(mm_sc), .mm_MemtoReg(mm_MemtoReg),
    .mm_RegWEN(mm_RegWEN), .mm_halt(mm_halt), .mm_rd(mm_rd),
    .mm_ALUOut(mm_ALUOut), .mm_store(mm_store), .mm_npc(mm_npc),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .mm_stall(mm_stall),
    .wb_valid(wb_valid), .wb_RegWEN(wb_RegWEN), .wb_halt(wb_halt),
    .wb_rd(wb_rd), .wb_wdat(wb_wdat), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic nop();
    mm_valid = 0; mm_dREN = 0; mm_dWEN = 0; mm_ll = 0; mm_sc = 0;
    mm_RegWEN = 0; mm_halt = 0; mm_MemtoReg = ALU; mm_rd = '0;
    mm_ALUOut = '0; mm_store = '0; mm_npc = '0; dhit = 0; dmemload = '0;
    snoop_inv = 0; snoop_addr = '0;
  endtask

  task automatic ll_200(input logic [31:0] load_val);
    nop();
    mm_valid = 1; mm_dREN = 1; mm_ll = 1; mm_MemtoReg = MEM; mm_RegWEN = 1;
    mm_rd = 5'd8; mm_ALUOut = 32'h200; dhit = 1; dmemload = load_val;
  endtask

  task automatic sc_200(input logic hit);
    nop();
    mm_valid = 1; mm_dWEN = 1; mm_sc = 1; mm_RegWEN = 1; mm_rd = 5'd9;
    mm_ALUOut = 32'h200; mm_store = 32'h1234; dhit = hit;
  endtask

  initial begin
    nop();
    RST = 1;
    step(); step();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_halt", 32'(wb_halt), 32'd0);
    chk("rst_wb_wdat", wb_wdat, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    RST = 0;
    step();

    // lw 0x100, dhit after 3 stall cycles
    mm_valid = 1; mm_dREN = 1; mm_MemtoReg = MEM; mm_RegWEN = 1;
    mm_rd = 5'd5; mm_ALUOut = 32'h100;
    #1;
    chk("lw_ren", 32'(dmemREN), 32'd1);
    chk("lw_addr", dmemaddr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("lw_stall", 32'(mm_stall), 32'd1);
      step();
      if (i < 2) chk("lw_no_wb", 32'(wb_valid), 32'd0);
    end
    chk("lw_ren_held", 32'(dmemREN), 32'd1);
    dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    chk("lw_stall_drop", 32'(mm_stall), 32'd0);
    step();
    nop();
    chk("lw_wb_valid", 32'(wb_valid), 32'd1);
    chk("lw_wdat", wb_wdat, 32'hDEADBEEF);
    chk("lw_rd", 32'(wb_rd), 32'd5);
    chk("lw_regwen", 32'(wb_RegWEN), 32'd1);
    chk("lw_stall_cnt", stall_cycles, 32'd3);
    step();
    chk("lw_wb_clear", 32'(wb_valid), 32'd0);

    // add then sw with dhit in the first cycle
    mm_valid = 1; mm_MemtoReg = ALU; mm_ALUOut = 32'h55; mm_rd = 5'd3; mm_RegWEN = 1;
    #1;
    chk("add_stall", 32'(mm_stall), 32'd0);
    chk("add_wen", 32'(dmemWEN), 32'd0);
    step();
    chk("add_wb_valid", 32'(wb_valid), 32'd1);
    chk("add_wdat", wb_wdat, 32'h55);
    chk("add_rd", 32'(wb_rd), 32'd3);
    nop();
    mm_valid = 1; mm_dWEN = 1; mm_ALUOut = 32'h300; mm_store = 32'hCAFEF00D; dhit = 1;
    #1;
    chk("sw_wen", 32'(dmemWEN), 32'd1);
    chk("sw_store", dmemstore, 32'hCAFEF00D);
    chk("sw_addr", dmemaddr, 32'h300);
    chk("sw_stall", 32'(mm_stall), 32'd0);
    step();
    chk("sw_wb_valid", 32'(wb_valid), 32'd1);
    chk("sw_regwen", 32'(wb_RegWEN), 32'd0);
    nop();
    #1;
    chk("sw_wen_drop", 32'(dmemWEN), 32'd0);
    chk("sw_stall_cnt", stall_cycles, 32'd3);
    step();
    chk("sw_wb_clear", 32'(wb_valid), 32'd0);

    // ll / sc success / second sc fails
    ll_200(32'h77);
    step();
    chk("ll_wdat", wb_wdat, 32'h77);
    sc_200(1'b1);
    #1;
    chk("sc1_wen", 32'(dmemWEN), 32'd1);
    step();
    chk("sc1_wdat", wb_wdat, 32'd1);
    chk("sc1_valid", 32'(wb_valid), 32'd1);
    sc_200(1'b1);
    #1;
    chk("sc2_wen", 32'(dmemWEN), 32'd0);
    chk("sc2_stall", 32'(mm_stall), 32'd0);
    step();
    chk("sc2_wdat", wb_wdat, 32'd0);
    chk("sc2_valid", 32'(wb_valid), 32'd1);
    chk("sc2_rd", 32'(wb_rd), 32'd9);

    // LL and snoop on the same address in the same cycle: LL wins
    ll_200(32'h0);
    snoop_inv = 1; snoop_addr = 32'h200;
    step();
    sc_200(1'b1);
    #1;
    chk("llwin_wen", 32'(dmemWEN), 32'd1);
    step();
    chk("llwin_wdat", wb_wdat, 32'd1);

    // snoop invalidate while sc stalled in REQ
    ll_200(32'h0);
    step();
    sc_200(1'b0);
    #1;
    chk("scinv_wen0", 32'(dmemWEN), 32'd1);
    chk("scinv_stall0", 32'(mm_stall), 32'd1);
    step();
    snoop_inv = 1; snoop_addr = 32'h200;
    #1;
    chk("scinv_wen1", 32'(dmemWEN), 32'd1);
    step();
    snoop_inv = 0;
    #1;
    chk("scinv_wen_drop", 32'(dmemWEN), 32'd0);
    chk("scinv_stall_drop", 32'(mm_stall), 32'd0);
    step();
    nop();
    chk("scinv_wb_valid", 32'(wb_valid), 32'd1);
    chk("scinv_wdat", wb_wdat, 32'd0);
    chk("scinv_stall_cnt", stall_cycles, 32'd5);

    // reset while a load is outstanding
    mm_valid = 1; mm_dREN = 1; mm_MemtoReg = MEM; mm_RegWEN = 1;
    mm_rd = 5'd7; mm_ALUOut = 32'h400;
    step();
    RST = 1;
    step();
    RST = 0;
    #1;
    chk("rreq_wb_valid", 32'(wb_valid), 32'd0);
    chk("rreq_ren", 32'(dmemREN), 32'd0);
    chk("rreq_stall", 32'(mm_stall), 32'd0);
    chk("rreq_cnt", stall_cycles, 32'd0);
    chk("rreq_wdat", wb_wdat, 32'd0);
    step();
    nop();
    chk("rreq_no_wb", 32'(wb_valid), 32'd0);
    step();

    // halt is sticky until reset
    mm_valid = 1; mm_halt = 1;
    step();
    chk("halt_wb_halt", 32'(wb_halt), 32'd1);
    chk("halt_wb_valid", 32'(wb_valid), 32'd1);
    nop();
    mm_valid = 1; mm_dREN = 1; mm_ALUOut = 32'h100; mm_RegWEN = 1;
    #1;
    chk("halted_ren", 32'(dmemREN), 32'd0);
    chk("halted_stall", 32'(mm_stall), 32'd1);
    step(); step();
    chk("halted_wb_valid", 32'(wb_valid), 32'd0);
    chk("halted_wb_halt", 32'(wb_halt), 32'd1);
    chk("halted_cnt", stall_cycles, 32'd0);
    RST = 1;
    step();
    RST = 0;
    nop();
    chk("halt_rst_clear", 32'(wb_halt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
